// File: rtl/bram0_loader.sv
// BRAM0 loader: writes a valid/ready stream of packed rows to consecutive
// BRAM0 addresses from 0, clamping the row count to the memory depth.
module bram0_loader #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 8,
  parameter int MEM_SIZE  = 256,
  parameter int CNT_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] load_count_i,
  input  logic                 s_valid_i,
  input  logic [DWIDTH-1:0]    s_data_i,
  output logic                 s_ready_o,
  output logic [AWIDTH-1:0]    addr_b0_o,
  output logic                 ce_b0_o,
  output logic                 we_b0_o,
  output logic [DWIDTH-1:0]    d_b0_o,
  output logic                 idle_o,
  output logic                 run_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] loaded_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MEM_SIZE_C = CNT_WIDTH'(MEM_SIZE);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE_C  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO_C = {CNT_WIDTH{1'b0}};

  state_t                state_r;
  state_t                next_state_s;
  logic [CNT_WIDTH-1:0]  target_r;
  logic [CNT_WIDTH-1:0]  target_s;
  logic [CNT_WIDTH-1:0]  loaded_cnt_r;
  logic [AWIDTH-1:0]     addr_r;
  logic [DWIDTH-1:0]     data_r;
  logic                  ce_r;
  logic                  we_r;
  logic                  hs_s;
  logic                  last_hs_s;

  assign s_ready_o = (state_r == S_RUN);
  assign hs_s      = s_valid_i & s_ready_o;
  // The last address is MEM_SIZE-1, so clamping the target rules out wrap.
  assign last_hs_s = hs_s & ((loaded_cnt_r + CNT_ONE_C) == target_r);

  // Clamp the requested row count to the BRAM0 depth.
  always_comb begin
    target_s = load_count_i;
    if (load_count_i > MEM_SIZE_C) begin
      target_s = MEM_SIZE_C;
    end else begin
      target_s = load_count_i;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_i) begin
          if (target_s == CNT_ZERO_C) begin
            next_state_s = S_DONE;
          end else begin
            next_state_s = S_RUN;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_hs_s) begin
          next_state_s = S_FLUSH;
        end else begin
          next_state_s = S_RUN;
        end
      end
      S_FLUSH: next_state_s = S_DONE;
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Target/count bookkeeping and the registered BRAM0 write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      target_r     <= CNT_ZERO_C;
      loaded_cnt_r <= CNT_ZERO_C;
      addr_r       <= {AWIDTH{1'b0}};
      data_r       <= {DWIDTH{1'b0}};
      ce_r         <= 1'b0;
      we_r         <= 1'b0;
    end else begin
      ce_r <= 1'b0;
      we_r <= 1'b0;
      if ((state_r == S_IDLE) && start_i) begin
        target_r     <= target_s;
        loaded_cnt_r <= CNT_ZERO_C;
      end
      if (hs_s) begin
        ce_r         <= 1'b1;
        we_r         <= 1'b1;
        addr_r       <= loaded_cnt_r[AWIDTH-1:0];
        data_r       <= s_data_i;
        loaded_cnt_r <= loaded_cnt_r + CNT_ONE_C;
      end
    end
  end

  assign addr_b0_o    = addr_r;
  assign d_b0_o       = data_r;
  assign ce_b0_o      = ce_r;
  assign we_b0_o      = we_r;
  assign loaded_cnt_o = loaded_cnt_r;
  assign idle_o       = (state_r == S_IDLE);
  assign run_o        = (state_r == S_RUN) || (state_r == S_FLUSH);
  assign done_o       = (state_r == S_DONE);

endmodule

// File: tb/tb_bram0_loader.sv
// Self-checking bench for bram0_loader: spec-level model compared every
// cycle, plus literal expectations on memory contents and pulse counts.
module tb_bram0_loader;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int MS = 256;
  localparam int CW = 9;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FLUSH = 2;
  localparam int M_DONE  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_i = 1'b0;
  logic [CW-1:0] load_count_i = '0;
  logic          s_valid_i = 1'b0;
  logic [DW-1:0] s_data_i = '0;
  logic          s_ready_o;
  logic [AW-1:0] addr_b0_o;
  logic          ce_b0_o;
  logic          we_b0_o;
  logic [DW-1:0] d_b0_o;
  logic          idle_o;
  logic          run_o;
  logic          done_o;
  logic [CW-1:0] loaded_cnt_o;

  bram0_loader #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .load_count_i(load_count_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .addr_b0_o(addr_b0_o), .ce_b0_o(ce_b0_o), .we_b0_o(we_b0_o), .d_b0_o(d_b0_o),
    .idle_o(idle_o), .run_o(run_o), .done_o(done_o), .loaded_cnt_o(loaded_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model state: what the spec says the outputs are in the coming cycle.
  int          m_mode = M_IDLE;
  int          m_target = 0;
  int          m_cnt = 0;
  bit          m_wr = 1'b0;
  int          m_addr = 0;
  logic [31:0] m_data = '0;
  bit          chk_en = 1'b0;

  logic [31:0] mem_model [MS];
  logic [31:0] mem_dut   [MS];
  int wr_cnt = 0;
  int done_cnt = 0;
  int rdy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mkword(input int i);
    mkword = {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)};
  endfunction

  // Compare DUT against the model, then advance the model on this cycle's inputs.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready",  64'(s_ready_o),    64'(m_mode == M_RUN));
      check("ce",     64'(ce_b0_o),      64'(m_wr));
      check("we",     64'(we_b0_o),      64'(m_wr));
      check("addr",   64'(addr_b0_o),    64'(m_addr));
      check("data",   64'(d_b0_o),       64'(m_data));
      check("idle",   64'(idle_o),       64'(m_mode == M_IDLE));
      check("run",    64'(run_o),        64'(m_mode == M_RUN || m_mode == M_FLUSH));
      check("done",   64'(done_o),       64'(m_mode == M_DONE));
      check("loaded", 64'(loaded_cnt_o), 64'(m_cnt));
      check("onehot", 64'(int'(idle_o) + int'(run_o) + int'(done_o)), 64'd1);
      check("we_ce",  64'(we_b0_o & ~ce_b0_o), 64'd0);
      if (ce_b0_o === 1'b1 && we_b0_o === 1'b1) begin
        mem_dut[addr_b0_o] = d_b0_o;
        wr_cnt++;
      end
      if (done_o === 1'b1) done_cnt++;
      if (s_ready_o === 1'b1) rdy_cnt++;
    end
    if (reset) begin
      m_mode = M_IDLE; m_cnt = 0; m_wr = 1'b0; m_addr = 0; m_data = '0;
      chk_en = 1'b1;
    end else begin
      m_wr = 1'b0;
      case (m_mode)
        M_IDLE: if (start_i) begin
          m_target = (int'(load_count_i) > MS) ? MS : int'(load_count_i);
          m_cnt = 0;
          m_mode = (m_target > 0) ? M_RUN : M_DONE;
        end
        M_RUN: if (s_valid_i) begin
          m_wr = 1'b1; m_addr = m_cnt; m_data = s_data_i;
          mem_model[m_cnt] = s_data_i;
          m_cnt++;
          if (m_cnt == m_target) m_mode = M_FLUSH;
        end
        M_FLUSH: m_mode = M_DONE;
        default: m_mode = M_IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_stats();
    wr_cnt = 0; done_cnt = 0; rdy_cnt = 0;
  endtask

  task automatic start_load(input int cnt);
    start_i = 1'b1; load_count_i = CW'(cnt);
    tick();
    start_i = 1'b0;
  endtask

  // Present one word after `gap` idle cycles and hold it until accepted.
  task automatic send(input int idx, input int gap);
    bit got;
    s_valid_i = 1'b0;
    repeat (gap) tick();
    s_valid_i = 1'b1; s_data_i = mkword(idx);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk); got = s_ready_o;
      tick();
    end
    s_valid_i = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL handshake_timeout: word %0d not accepted, want accepted", idx);
    end
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk); seen = idle_o;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL idle_timeout: idle_o=%0b want 1", idle_o);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < MS; i++) begin
      mem_model[i] = '0; mem_dut[i] = '0;
    end
    tick(); tick();
    reset = 1'b0;

    // Reset mid-load, then a clean reload.
    start_load(4);
    send(0, 0); send(1, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clk);
    check("rst_ce", 64'(ce_b0_o), 64'd0);
    check("rst_loaded", 64'(loaded_cnt_o), 64'd0);
    check("rst_idle", 64'(idle_o), 64'd1);
    tick();
    clear_stats();
    start_load(4);
    for (int i = 0; i < 4; i++) send(10 + i, 0);
    wait_idle();
    check("rst_reload_writes", 64'(wr_cnt), 64'd4);
    for (int i = 0; i < 4; i++) check("rst_reload_mem", 64'(mem_dut[i]), 64'(mkword(10 + i)));

    // Back-to-back load of four words.
    clear_stats();
    start_load(4);
    for (int i = 0; i < 4; i++) send(i, 0);
    wait_idle();
    check("b2b_writes", 64'(wr_cnt), 64'd4);
    check("b2b_done", 64'(done_cnt), 64'd1);
    check("b2b_mem0", 64'(mem_dut[0]), 64'h04030201);
    check("b2b_mem1", 64'(mem_dut[1]), 64'h08070605);
    check("b2b_mem2", 64'(mem_dut[2]), 64'h0C0B0A09);
    check("b2b_mem3", 64'(mem_dut[3]), 64'h100F0E0D);

    // Stalled stream: gaps of 0, 2 and 5 cycles.
    clear_stats();
    start_load(3);
    send(20, 0); send(21, 2); send(22, 5);
    wait_idle();
    check("stall_writes", 64'(wr_cnt), 64'd3);
    check("stall_ready_cycles", 64'(rdy_cnt), 64'd10);
    check("stall_mem2", 64'(mem_dut[2]), 64'(mkword(22)));

    // Zero count.
    clear_stats();
    start_load(0);
    wait_idle();
    check("zero_done", 64'(done_cnt), 64'd1);
    check("zero_writes", 64'(wr_cnt), 64'd0);
    check("zero_ready", 64'(rdy_cnt), 64'd0);

    // Overflow clamp: 300 requested, 256 written.
    clear_stats();
    start_load(300);
    for (int i = 0; i < 256; i++) send(i, 0);
    s_valid_i = 1'b1;
    for (int j = 0; j < 44; j++) begin
      s_data_i = mkword(256 + j);
      tick();
    end
    s_valid_i = 1'b0;
    wait_idle();
    check("ovf_writes", 64'(wr_cnt), 64'd256);
    check("ovf_loaded", 64'(loaded_cnt_o), 64'd256);
    check("ovf_done", 64'(done_cnt), 64'd1);
    check("ovf_mem255", 64'(mem_dut[255]), 64'(mkword(255)));

    // Ignored start during RUN.
    clear_stats();
    start_load(2);
    send(40, 0);
    start_load(7);
    send(41, 0);
    wait_idle();
    repeat (4) tick();
    check("ign_loaded", 64'(loaded_cnt_o), 64'd2);
    check("ign_writes", 64'(wr_cnt), 64'd2);
    check("ign_done", 64'(done_cnt), 64'd1);
    check("ign_idle", 64'(idle_o), 64'd1);

    for (int i = 0; i < MS; i++) check("mem_model", 64'(mem_dut[i]), 64'(mem_model[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
